stop_watch_timer: RTL and testbench

STOP_WATCH_TIMER -- requirements
Module: stop_watch_timer

---
 rtl/stop_watch_timer.sv | 128 ++++++++++++
 tb/tb_stop_watch_timer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/stop_watch_timer.sv
// Stopwatch / countdown timer with a prescaled tick, pause/resume, and lap capture.
// All state lives in one clocked FSM block, so every output is registered.
module stop_watch_timer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX        = 99,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  lap,
    output logic [DATA_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0] lap_count,
    output logic                  running,
    output logic                  wrap,
    output logic                  done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX_V   = DATA_WIDTH'(MAX);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);
    localparam logic [PW-1:0]         PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]         PS_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_e;

    state_e                  state_q;
    logic                    dir_q;
    logic [PW-1:0]           psc_q;
    logic [DATA_WIDTH-1:0]   count_q;
    logic [DATA_WIDTH-1:0]   lap_q;
    logic                    running_q;
    logic                    wrap_q;
    logic                    done_q;

    assign count     = count_q;
    assign lap_count = lap_q;
    assign running   = running_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            psc_q     <= '0;
            count_q   <= '0;
            lap_q     <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            if (clear) begin
                state_q   <= IDLE;
                psc_q     <= '0;
                count_q   <= '0;
                lap_q     <= '0;
                running_q <= 1'b0;
            end else begin
                // Lap samples the pre-edge count, so it races nothing below.
                if (lap && state_q != IDLE) begin
                    lap_q <= count_q;
                end
                unique case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                            dir_q     <= mode;
                            psc_q     <= '0;
                            if (mode) begin
                                count_q <= (load_val > MAX_V) ? MAX_V : load_val;
                            end else begin
                                count_q <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else if (psc_q != PS_LAST) begin
                            psc_q <= psc_q + PS_ONE;
                        end else begin
                            psc_q <= '0;
                            if (!dir_q) begin
                                if (count_q >= MAX_V) begin
                                    count_q <= '0;
                                    wrap_q  <= 1'b1;
                                end else begin
                                    count_q <= count_q + CNT_ONE;
                                end
                            end else if (count_q == '0) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                count_q <= count_q - CNT_ONE;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stop_watch_timer.sv
// Directed bench: dut_a runs with PRESCALE=1, dut_b with PRESCALE=4; both share the inputs.
module tb_stop_watch_timer;

    logic        clk = 1'b0;
    logic        resetn, start, stop, clear, mode, lap;
    logic [15:0] load_val;
    logic [15:0] count_a, lap_a, count_b, lap_b;
    logic        running_a, wrap_a, done_a, running_b, wrap_b, done_b;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    stop_watch_timer #(.DATA_WIDTH(16), .MAX(99), .PRESCALE(1)) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .load_val(load_val), .lap(lap),
        .count(count_a), .lap_count(lap_a), .running(running_a), .wrap(wrap_a), .done(done_a)
    );

    stop_watch_timer #(.DATA_WIDTH(16), .MAX(99), .PRESCALE(4)) dut_b (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .load_val(load_val), .lap(lap),
        .count(count_b), .lap_count(lap_b), .running(running_b), .wrap(wrap_b), .done(done_b)
    );

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; lap = 1'b1; mode = 1'b1; load_val = 16'd7;
        step(2);
        tests++; if (count_a !== 16'd0) begin fails++; $display("FAIL reset_count_a got %0d exp 0", count_a); end
        tests++; if (lap_a !== 16'd0) begin fails++; $display("FAIL reset_lap_a got %0d exp 0", lap_a); end
        tests++; if ({running_a, wrap_a, done_a} !== 3'b000) begin fails++; $display("FAIL reset_flags_a got %b exp 000", {running_a, wrap_a, done_a}); end
        tests++; if ({running_b, wrap_b, done_b, count_b} !== 19'd0) begin fails++; $display("FAIL reset_b got %0d/%b exp 0/000", count_b, {running_b, wrap_b, done_b}); end
        resetn = 1'b1; start = 1'b0; lap = 1'b0; mode = 1'b0; load_val = 16'd0;
        step(2);
        tests++; if (running_a !== 1'b0) begin fails++; $display("FAIL idle_after_reset got %b exp 0", running_a); end
        stop = 1'b1; step(1); stop = 1'b0;
        tests++; if ({running_a, count_a} !== 17'd0) begin fails++; $display("FAIL stop_in_idle got %0d/%b exp 0/0", count_a, running_a); end
    endtask

    task automatic test_up_wrap();
        do_clear();
        mode = 1'b0; start = 1'b1; step(1);
        tests++; if (running_a !== 1'b1 || count_a !== 16'd0) begin fails++; $display("FAIL up_start got %0d/%b exp 0/1", count_a, running_a); end
        step(1);
        tests++; if (count_a !== 16'd1) begin fails++; $display("FAIL up_first_tick got %0d exp 1", count_a); end
        step(2);
        tests++; if (count_a !== 16'd3) begin fails++; $display("FAIL start_held_in_run got %0d exp 3", count_a); end
        start = 1'b0;
        step(96);
        tests++; if (count_a !== 16'd99 || wrap_a !== 1'b0) begin fails++; $display("FAIL up_at_max got %0d/%b exp 99/0", count_a, wrap_a); end
        step(1);
        tests++; if (count_a !== 16'd0 || wrap_a !== 1'b1 || running_a !== 1'b1) begin fails++; $display("FAIL up_wrap got %0d/%b/%b exp 0/1/1", count_a, wrap_a, running_a); end
        step(1);
        tests++; if (count_a !== 16'd1 || wrap_a !== 1'b0) begin fails++; $display("FAIL wrap_pulse_end got %0d/%b exp 1/0", count_a, wrap_a); end
        do_clear();
        tests++; if (count_a !== 16'd0 || running_a !== 1'b0) begin fails++; $display("FAIL clear_run got %0d/%b exp 0/0", count_a, running_a); end
    endtask

    task automatic test_prescale();
        do_clear();
        mode = 1'b0; start = 1'b1; step(1); start = 1'b0;
        step(3);
        tests++; if (count_b !== 16'd0) begin fails++; $display("FAIL ps_before_tick got %0d exp 0", count_b); end
        step(1);
        tests++; if (count_b !== 16'd1) begin fails++; $display("FAIL ps_first_tick got %0d exp 1", count_b); end
        step(6);
        stop = 1'b1; step(1);
        tests++; if (count_b !== 16'd2 || running_b !== 1'b0) begin fails++; $display("FAIL ps_stop got %0d/%b exp 2/0", count_b, running_b); end
        step(20);
        tests++; if (count_b !== 16'd2) begin fails++; $display("FAIL ps_hold got %0d exp 2", count_b); end
        stop = 1'b0; start = 1'b1; step(1); start = 1'b0;
        tests++; if (count_b !== 16'd2 || running_b !== 1'b1) begin fails++; $display("FAIL ps_resume got %0d/%b exp 2/1", count_b, running_b); end
        step(1);
        tests++; if (count_b !== 16'd2) begin fails++; $display("FAIL ps_resume_1 got %0d exp 2", count_b); end
        step(1);
        tests++; if (count_b !== 16'd3) begin fails++; $display("FAIL ps_resume_2 got %0d exp 3", count_b); end
    endtask

    task automatic test_down();
        logic [15:0] exp_seq [5] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        do_clear();
        mode = 1'b1; load_val = 16'd5; start = 1'b1; step(1);
        start = 1'b0; mode = 1'b0; load_val = 16'd77;
        tests++; if (count_a !== 16'd5 || running_a !== 1'b1) begin fails++; $display("FAIL down_load got %0d/%b exp 5/1", count_a, running_a); end
        for (int i = 0; i < 5; i++) begin
            step(1);
            tests++; if (count_a !== exp_seq[i] || done_a !== 1'b0) begin fails++; $display("FAIL down_seq%0d got %0d/%b exp %0d/0", i, count_a, done_a, exp_seq[i]); end
        end
        step(1);
        tests++; if (done_a !== 1'b1 || running_a !== 1'b0 || count_a !== 16'd0) begin fails++; $display("FAIL down_done got %0d/%b/%b exp 0/1/0", count_a, done_a, running_a); end
        step(1);
        tests++; if (done_a !== 1'b0 || count_a !== 16'd0) begin fails++; $display("FAIL done_pulse_end got %0d/%b exp 0/0", count_a, done_a); end
        mode = 1'b1; load_val = 16'd200; start = 1'b1; step(1); start = 1'b0;
        tests++; if (count_a !== 16'd99 || running_a !== 1'b1) begin fails++; $display("FAIL down_clamp got %0d/%b exp 99/1", count_a, running_a); end
        step(1);
        tests++; if (count_a !== 16'd98) begin fails++; $display("FAIL down_clamp_tick got %0d exp 98", count_a); end
        do_clear();
        load_val = 16'd0; start = 1'b1; step(1); start = 1'b0;
        tests++; if (running_a !== 1'b1 || count_a !== 16'd0) begin fails++; $display("FAIL zero_load_run got %0d/%b exp 0/1", count_a, running_a); end
        step(1);
        tests++; if (done_a !== 1'b1 || running_a !== 1'b0) begin fails++; $display("FAIL zero_load_done got %b/%b exp 1/0", done_a, running_a); end
        mode = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_clear();
        mode = 1'b0; start = 1'b1; step(1); start = 1'b0;
        step(3);
        stop = 1'b1; start = 1'b1; step(1);
        tests++; if (count_a !== 16'd3 || running_a !== 1'b0) begin fails++; $display("FAIL stop_start got %0d/%b exp 3/0", count_a, running_a); end
        stop = 1'b0; clear = 1'b1; step(1); clear = 1'b0; start = 1'b0;
        tests++; if (count_a !== 16'd0 || running_a !== 1'b0) begin fails++; $display("FAIL clear_start got %0d/%b exp 0/0", count_a, running_a); end
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        lap = 1'b1; step(1);
        tests++; if (lap_a !== 16'd4) begin fails++; $display("FAIL lap_pre got %0d exp 4", lap_a); end
        clear = 1'b1; step(1); clear = 1'b0; lap = 1'b0;
        tests++; if (lap_a !== 16'd0 || count_a !== 16'd0) begin fails++; $display("FAIL lap_clear got %0d/%0d exp 0/0", lap_a, count_a); end
        lap = 1'b1; step(1); lap = 1'b0;
        tests++; if (lap_a !== 16'd0) begin fails++; $display("FAIL lap_idle got %0d exp 0", lap_a); end
    endtask

    task automatic test_lap_and_reset();
        do_clear();
        mode = 1'b0; start = 1'b1; step(1); start = 1'b0;
        step(37);
        tests++; if (count_a !== 16'd37) begin fails++; $display("FAIL lap_reach got %0d exp 37", count_a); end
        lap = 1'b1; step(1); lap = 1'b0;
        tests++; if (lap_a !== 16'd37 || count_a !== 16'd38) begin fails++; $display("FAIL lap_37 got %0d/%0d exp 37/38", lap_a, count_a); end
        step(12);
        tests++; if (count_a !== 16'd50 || lap_a !== 16'd37) begin fails++; $display("FAIL lap_hold got %0d/%0d exp 50/37", count_a, lap_a); end
        resetn = 1'b0; step(1);
        tests++; if ({count_a, lap_a, running_a, wrap_a, done_a} !== 35'd0) begin fails++; $display("FAIL midrun_reset got %0d/%0d/%b exp 0/0/000", count_a, lap_a, {running_a, wrap_a, done_a}); end
        resetn = 1'b1; step(3);
        tests++; if (count_a !== 16'd0 || running_a !== 1'b0) begin fails++; $display("FAIL need_restart got %0d/%b exp 0/0", count_a, running_a); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        mode = 1'b0; lap = 1'b0; load_val = 16'd0;
        test_reset();
        test_up_wrap();
        test_prescale();
        test_down();
        test_simultaneous();
        test_lap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
